// File: rtl/cpu_mem_ctrl_if.sv
// rtl/cpu_mem_ctrl_if.sv - core-side fetch/data bus of the unified memory controller
interface cpu_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              enable;
    logic [ADDR_W-1:0] PC;
    logic              if_req;
    logic [DATA_W-1:0] ins;
    logic              ins_valid;
    logic [ADDR_W-1:0] DataAdr;
    logic [DATA_W-1:0] WriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] ReadData;
    logic              data_valid;
    logic              stall;
    logic              bus_err;
    logic [DATA_W-1:0] mmio_out;

    modport master (
        output enable, PC, if_req, DataAdr, WriteData, MemWrite, MemRead,
        input  ins, ins_valid, ReadData, data_valid, stall, bus_err, mmio_out
    );

    modport slave (
        input  enable, PC, if_req, DataAdr, WriteData, MemWrite, MemRead,
        output ins, ins_valid, ReadData, data_valid, stall, bus_err, mmio_out
    );
endinterface

// File: rtl/cpu_mem_ctrl.sv
// rtl/cpu_mem_ctrl.sv - unified fetch/data memory controller with wait states; CPU_MEM_MMIO_EN adds one MMIO output register
module cpu_mem_ctrl #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 256,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] MMIO_BASE   = 'h400
) (
    input logic          clk,
    input logic          reset,
    cpu_mem_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
`ifdef CPU_MEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              sel_data_q;
    logic              wr_q;
    logic              rd_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ins_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mmio_val;

    logic              data_req;
    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              mmio_hit;
    logic [DATA_W-1:0] rd_word;

    assign data_req = bus.MemWrite | bus.MemRead;
    assign accept   = (state == IDLE) && bus.enable && (data_req || bus.if_req);
    assign idx      = addr_q[IDX_W+1:2];
    assign in_range = (addr_q >> (IDX_W + 2)) == '0;
    assign mmio_hit = MMIO_EN && (addr_q == MMIO_BASE);
    // Word seen by the served port in DONE; a combined read/write sees the pre-write word.
    assign rd_word  = mmio_hit ? mmio_val : (in_range ? mem[idx] : '0);

    // State register and wait-state counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == BUSY)
                cnt <= CNT_INIT;
            else if (state == BUSY && cnt != 3'd0)
                cnt <= cnt - 3'd1;
        end
    end

    // Next-state logic: IDLE accepts (data before fetch), BUSY counts, DONE completes
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WAIT_STATES == 0) ? DONE : BUSY;
            BUSY:    if (cnt == 3'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: completion pulses, error flag, stall and held result words
    always_comb begin
        bus.data_valid = (state == DONE) && sel_data_q;
        bus.ins_valid  = (state == DONE) && !sel_data_q;
        bus.bus_err    = (state == DONE) && !in_range && !mmio_hit;
        bus.stall      = (state != DONE) && (data_req || bus.if_req);
        bus.ins        = ((state == DONE) && !sel_data_q) ? rd_word : ins_q;
        bus.ReadData   = ((state == DONE) && sel_data_q && rd_q) ? rd_word : rdata_q;
        bus.mmio_out   = mmio_val;
    end

    // Latch the accepted request so later input changes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_data_q <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
        end else if (accept) begin
            sel_data_q <= data_req;
            wr_q       <= bus.MemWrite;
            rd_q       <= bus.MemRead;
            addr_q     <= data_req ? bus.DataAdr : bus.PC;
            wdata_q    <= bus.WriteData;
        end
    end

    // Capture the served word so ins/ReadData hold between completions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ins_q   <= '0;
            rdata_q <= '0;
        end else if (state == DONE) begin
            if (!sel_data_q)
                ins_q <= rd_word;
            else if (rd_q)
                rdata_q <= rd_word;
        end
    end

    // Array write at the end of DONE; reset before then leaves the word untouched
    always_ff @(posedge clk) begin
        if (state == DONE && sel_data_q && wr_q && in_range && !mmio_hit)
            mem[idx] <= wdata_q;
    end

`ifdef CPU_MEM_MMIO_EN
    logic [DATA_W-1:0] mmio_q;

    // Memory-mapped output register, written by a store to exactly MMIO_BASE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mmio_q <= '0;
        else if (state == DONE && sel_data_q && wr_q && mmio_hit)
            mmio_q <= wdata_q;
    end

    assign mmio_val = mmio_q;
`else
    assign mmio_val = '0;
`endif
endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb/tb_cpu_mem_ctrl.sv - self-checking bench for cpu_mem_ctrl (W=1 and W=0 instances)
module tb_cpu_mem_ctrl;
`ifdef CPU_MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          chk;
        bit          err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        bit          chk;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t dq[$];
    logic [31:0] iq[$];

    always #5 clk = ~clk;

    cpu_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) i0 ();
    cpu_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) i1 ();

    cpu_mem_ctrl #(.WAIT_STATES(1)) u0 (.clk(clk), .reset(reset), .bus(i0));
    cpu_mem_ctrl #(.WAIT_STATES(0)) u1 (.clk(clk), .reset(reset), .bus(i1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard for the W=1 instance: every completion pops one expectation.
    always @(negedge clk) begin
        if (reset && i0.data_valid) begin
            if (dq.size() == 0) begin
                check("sb_unexpected_data_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = dq.pop_front();
                if (e.chk) check("sb_ReadData", i0.ReadData, e.rd);
                check("sb_data_bus_err", 32'(i0.bus_err), 32'(e.err));
            end
        end
        if (reset && i0.ins_valid) begin
            if (iq.size() == 0) begin
                check("sb_unexpected_ins_valid", 32'd1, 32'd0);
            end else begin
                logic [31:0] w;
                w = iq.pop_front();
                check("sb_ins", i0.ins, w);
                check("sb_ins_bus_err", 32'(i0.bus_err), 32'd0);
            end
        end
    end

    task automatic dut0_data(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input bit chk, input bit err,
                             output int lat, output bit st_done);
        @(negedge clk);
        i0.MemWrite = wr; i0.MemRead = rd; i0.DataAdr = a; i0.WriteData = wd;
        dq.push_back('{exp_rd, chk, err});
        lat = -1;
        st_done = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (i0.data_valid) begin
                lat = c;
                st_done = i0.stall;
                break;
            end
        end
        i0.MemWrite = 1'b0; i0.MemRead = 1'b0;
        if (lat < 0) check("data_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[18];
        int lat;
        bit st;
        logic [5:0] st_exp;
        logic [31:0] pcs[3];
        logic [31:0] words[3];

        vt[0]  = '{1, 0, 32'h10,        32'hDEADBEEF, 32'h0,        0, 0};
        vt[1]  = '{0, 1, 32'h10,        32'h0,        32'hDEADBEEF, 1, 0};
        vt[2]  = '{1, 0, 32'h0,         32'h11111111, 32'h0,        0, 0};
        vt[3]  = '{1, 0, 32'h4,         32'h22222222, 32'h0,        0, 0};
        vt[4]  = '{1, 0, 32'h8,         32'h88888888, 32'h0,        0, 0};
        vt[5]  = '{1, 0, 32'h3FC,       32'hAAAA5555, 32'h0,        0, 0};
        vt[6]  = '{1, 0, 32'h3F0,       32'h0F0F0F0F, 32'h0,        0, 0};
        vt[7]  = '{0, 1, 32'h5,         32'h0,        32'h22222222, 1, 0};
        vt[8]  = '{1, 1, 32'h0,         32'h33333333, 32'h11111111, 1, 0};
        vt[9]  = '{0, 1, 32'h0,         32'h0,        32'h33333333, 1, 0};
        vt[10] = '{0, 1, 32'h3FC,       32'h0,        32'hAAAA5555, 1, 0};
        vt[11] = '{0, 1, 32'h400,       32'h0,        32'h0,        1, !MMIO};
        vt[12] = '{1, 0, 32'h400,       32'h000000A5, 32'h0,        0, !MMIO};
        vt[13] = '{0, 1, 32'h0,         32'h0,        32'h33333333, 1, 0};
        vt[14] = '{0, 1, 32'h400,       32'h0,        MMIO ? 32'hA5 : 32'h0, 1, !MMIO};
        vt[15] = '{0, 1, 32'h404,       32'h0,        32'h0,        1, 1};
        vt[16] = '{1, 0, 32'hFFFFFFF0,  32'h12345678, 32'h0,        0, 1};
        vt[17] = '{0, 1, 32'h3F0,       32'h0,        32'h0F0F0F0F, 1, 0};

        i0.enable = 1'b1; i0.PC = '0; i0.if_req = 1'b0; i0.DataAdr = '0;
        i0.WriteData = '0; i0.MemWrite = 1'b0; i0.MemRead = 1'b0;
        i1.enable = 1'b1; i1.PC = '0; i1.if_req = 1'b0; i1.DataAdr = '0;
        i1.WriteData = '0; i1.MemWrite = 1'b0; i1.MemRead = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ins",        i0.ins, 32'h0);
        check("rst_ReadData",   i0.ReadData, 32'h0);
        check("rst_valids",     {30'd0, i0.ins_valid, i0.data_valid}, 32'h0);
        check("rst_bus_err",    32'(i0.bus_err), 32'h0);
        check("rst_mmio_out",   i0.mmio_out, 32'h0);
        check("rst_stall",      32'(i0.stall), 32'h0);
        check("rst1_outputs",   i1.ins | i1.ReadData, 32'h0);

        for (int k = 0; k < 18; k++) begin
            dut0_data(vt[k].wr, vt[k].rd, vt[k].addr, vt[k].wdata, vt[k].exp_rd, vt[k].chk, vt[k].err, lat, st);
            check($sformatf("v%0d_latency", k), 32'(lat), 32'd2);
            check($sformatf("v%0d_stall_in_done", k), 32'(st), 32'd0);
        end
        check("mmio_out_after_store", i0.mmio_out, MMIO ? 32'hA5 : 32'h0);

        // Fetch and load together: data first, then fetch after one IDLE cycle.
        st_exp = 6'b011011;
        @(negedge clk);
        i0.if_req = 1'b1; i0.PC = 32'h0; i0.MemRead = 1'b1; i0.DataAdr = 32'h8;
        dq.push_back('{32'h88888888, 1, 0});
        iq.push_back(32'h33333333);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check($sformatf("both_stall_c%0d", c), 32'(i0.stall), 32'(st_exp[c]));
            check($sformatf("both_data_valid_c%0d", c), 32'(i0.data_valid), 32'(c == 2));
            check($sformatf("both_ins_valid_c%0d", c), 32'(i0.ins_valid), 32'(c == 5));
            if (c == 2) i0.MemRead = 1'b0;
            if (c == 5) i0.if_req = 1'b0;
        end

        // Back-to-back fetches: one word every W+2 = 3 cycles.
        pcs[0] = 32'h0;  pcs[1] = 32'h4;  pcs[2] = 32'h10;
        words[0] = 32'h33333333; words[1] = 32'h22222222; words[2] = 32'hDEADBEEF;
        @(negedge clk);
        i0.if_req = 1'b1; i0.PC = pcs[0];
        iq.push_back(words[0]);
        begin
            int k;
            k = 0;
            for (int c = 0; c < 9; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                check($sformatf("b2b_ins_valid_c%0d", c), 32'(i0.ins_valid), 32'(c == 2 || c == 5 || c == 8));
                if (i0.ins_valid) begin
                    k++;
                    if (k < 3) begin
                        i0.PC = pcs[k];
                        iq.push_back(words[k]);
                    end else begin
                        i0.if_req = 1'b0;
                    end
                end
            end
            i0.if_req = 1'b0;
        end

        // Reset in the middle of a store: nothing committed, outputs cleared.
        dut0_data(1, 0, 32'h20, 32'h20202020, 32'h0, 0, 0, lat, st);
        dut0_data(0, 1, 32'h20, 32'h0, 32'h20202020, 1, 0, lat, st);
        @(negedge clk);
        i0.MemWrite = 1'b1; i0.DataAdr = 32'h20; i0.WriteData = 32'hBAD0BAD0;
        @(negedge clk);
        #1;
        check("busy_no_valid", 32'(i0.data_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_ReadData", i0.ReadData, 32'h0);
        check("midrst_ins",      i0.ins, 32'h0);
        check("midrst_valids",   {29'd0, i0.bus_err, i0.ins_valid, i0.data_valid}, 32'h0);
        check("midrst_mmio_out", i0.mmio_out, 32'h0);
        check("midrst_stall",    32'(i0.stall), 32'd1);
        i0.MemWrite = 1'b0;
        #1;
        check("midrst_stall_norq", 32'(i0.stall), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("postrst_no_valid_c%0d", c), 32'(i0.data_valid), 32'd0);
        end
        dut0_data(0, 1, 32'h20, 32'h0, 32'h20202020, 1, 0, lat, st);

        // W=0 instance: single-cycle store, then fetch held off by enable.
        @(negedge clk);
        i1.MemWrite = 1'b1; i1.DataAdr = 32'h0; i1.WriteData = 32'h5A5A5A5A;
        #1;
        check("w0_store_c0_valid", 32'(i1.data_valid), 32'd0);
        @(negedge clk);
        #1;
        check("w0_store_c1_valid", 32'(i1.data_valid), 32'd1);
        i1.MemWrite = 1'b0;
        @(negedge clk);
        i1.enable = 1'b0; i1.if_req = 1'b1; i1.PC = 32'h0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check($sformatf("w0_en_low_stall_c%0d", c), 32'(i1.stall), 32'd1);
            check($sformatf("w0_en_low_ins_valid_c%0d", c), 32'(i1.ins_valid), 32'd0);
        end
        @(negedge clk);
        i1.enable = 1'b1;
        #1;
        check("w0_en_high_c0_valid", 32'(i1.ins_valid), 32'd0);
        @(negedge clk);
        #1;
        check("w0_en_high_c1_valid", 32'(i1.ins_valid), 32'd1);
        check("w0_ins", i1.ins, 32'h5A5A5A5A);
        i1.if_req = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_data_drained", 32'(dq.size()), 32'd0);
        check("sb_ins_drained",  32'(iq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
